// File: rtl/mac_accum.sv
// Multiply-accumulate back end: sums NTERMS unsigned products per result and holds it under valid/ready.
// Define MAC_ACCUM_SATURATE_EN to clamp the accumulator at all-ones instead of wrapping.
module mac_accum #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 16,
  parameter int NTERMS    = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] prod,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  output logic [ACCWIDTH-1:0]  acc,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 busy
);

  localparam int CNT_W = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NTERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e               state_q, state_d;
  logic [ACCWIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 vld_q, vld_d;

  // Once a sum overflows it stays clamped, since every later term is non-negative.
  function automatic logic [ACCWIDTH-1:0] add_term(input logic [ACCWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] p);
`ifdef MAC_ACCUM_SATURATE_EN
    logic [ACCWIDTH:0] s;
    s = {1'b0, a} + (ACCWIDTH + 1)'(p);
    return s[ACCWIDTH] ? {ACCWIDTH{1'b1}} : s[ACCWIDTH-1:0];
`else
    return a + ACCWIDTH'(p);
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d = add_term(acc_q, prod);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          vld_d = 1'b0;
          // start together with acc_ready chains straight into the next accumulation
          if (start) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign acc        = acc_q;
  assign acc_valid  = vld_q;

endmodule

// File: tb/tb_mac_accum.sv
// Randomized self-checking bench for mac_accum; runs a 16-bit and a 9-bit accumulator side by side.
module tb_mac_accum;

  logic       Clk = 1'b0;
  logic       Rst, start, prod_valid, acc_ready;
  logic [7:0] prod;

  logic        prod_ready_a, busy_a, acc_valid_a;
  logic [15:0] acc_a;
  logic        prod_ready_b, busy_b, acc_valid_b;
  logic [8:0]  acc_b;

  int n_cmp = 0;
  int n_err = 0;
  int q_terms[$];

  always #5 Clk = ~Clk;

  mac_accum #(.DATAWIDTH(8), .ACCWIDTH(16), .NTERMS(4)) u_dut_a (
    .Clk(Clk), .Rst(Rst), .start(start), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(prod_ready_a), .acc(acc_a), .acc_valid(acc_valid_a),
    .acc_ready(acc_ready), .busy(busy_a)
  );

  mac_accum #(.DATAWIDTH(8), .ACCWIDTH(9), .NTERMS(4)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .start(start), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(prod_ready_b), .acc(acc_b), .acc_valid(acc_valid_b),
    .acc_ready(acc_ready), .busy(busy_b)
  );

  // Expected result of the current transaction: plain integer sum, then wrapped or clamped.
  function automatic longint exp_val(input int w);
    longint s = 0;
    longint m = longint'(1) << w;
    foreach (q_terms[i]) s += q_terms[i];
`ifdef MAC_ACCUM_SATURATE_EN
    return (s > m - 1) ? m - 1 : s;
`else
    return s % m;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input bit ready, input bit bsy, input bit vld);
    check({tag, "_prod_ready_a"}, prod_ready_a, ready);
    check({tag, "_busy_a"}, busy_a, bsy);
    check({tag, "_acc_valid_a"}, acc_valid_a, vld);
    check({tag, "_prod_ready_b"}, prod_ready_b, ready);
    check({tag, "_busy_b"}, busy_b, bsy);
    check({tag, "_acc_valid_b"}, acc_valid_b, vld);
  endtask

  task automatic check_acc(input string tag, input longint ea, input longint eb);
    check({tag, "_acc_a"}, acc_a, 32'(ea));
    check({tag, "_acc_b"}, acc_b, 32'(eb));
  endtask

  // All tasks start and end just after a falling edge.
  task automatic begin_txn(input string tag);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check_ctrl({tag, "_start"}, 1'b1, 1'b1, 1'b0);
    check_acc({tag, "_start"}, 0, 0);
  endtask

  // gap_mode: 0 none, 1 idle cycle before every term after the first, 2 random idles
  task automatic feed(input string tag, input int gap_mode, input bit start_mid);
    foreach (q_terms[i]) begin
      int gaps = 0;
      if (gap_mode == 1 && i > 0) gaps = 1;
      if (gap_mode == 2) gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        prod_valid = 1'b0;
        prod = 8'($urandom);
        @(negedge Clk);
        check({tag, "_gap_vld"}, acc_valid_a, 1'b0);
        check({tag, "_gap_ready"}, prod_ready_a, 1'b1);
      end
      if (start_mid && i == 2) start = 1'b1;
      prod = 8'(q_terms[i]);
      prod_valid = 1'b1;
      @(negedge Clk);
      start = 1'b0;
    end
    prod_valid = 1'b0;
  endtask

  task automatic finish_txn(input string tag, input int hold, input bit b2b);
    longint ea = exp_val(16);
    longint eb = exp_val(9);
    check_ctrl({tag, "_done"}, 1'b0, 1'b1, 1'b1);
    check_acc({tag, "_done"}, ea, eb);
    repeat (hold) begin
      @(negedge Clk);
      check_ctrl({tag, "_hold"}, 1'b0, 1'b1, 1'b1);
      check_acc({tag, "_hold"}, ea, eb);
    end
    acc_ready = 1'b1;
    start = b2b;
    @(negedge Clk);
    acc_ready = 1'b0;
    start = 1'b0;
    check_ctrl({tag, "_release"}, b2b, b2b, 1'b0);
    if (b2b) check_acc({tag, "_b2b"}, 0, 0);
    else     check_acc({tag, "_idle"}, ea, eb);
  endtask

  initial begin
    bit in_accum;
    Rst = 1'b0; start = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0; prod = '0;
    #1;
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check_acc("reset", 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // basic sum with held result
    q_terms = '{10, 20, 30, 40};
    begin_txn("t1");
    feed("t1", 0, 1'b0);
    finish_txn("t1", 5, 1'b0);

    // valid gaps, then prod_valid in IDLE is ignored
    q_terms = '{1, 2, 3, 4};
    begin_txn("t2");
    feed("t2", 1, 1'b0);
    finish_txn("t2", 0, 1'b0);
    prod = 8'd99;
    prod_valid = 1'b1;
    repeat (2) @(negedge Clk);
    prod_valid = 1'b0;
    check_ctrl("t2_idle_pv", 1'b0, 1'b0, 1'b0);
    check_acc("t2_idle_pv", 10, 10);

    // back-to-back: release with start goes straight to ACCUM
    q_terms = '{10, 20, 30, 40};
    begin_txn("t4");
    feed("t4", 0, 1'b0);
    finish_txn("t4", 2, 1'b1);
    q_terms = '{5, 5, 5, 5};
    feed("t4b", 0, 1'b0);
    finish_txn("t4b", 0, 1'b0);

    // overflow of the narrow accumulator
    q_terms = '{255, 255, 255, 255};
    begin_txn("t3");
    feed("t3", 0, 1'b0);
    finish_txn("t3", 1, 1'b0);

    // start during ACCUM is ignored
    q_terms = '{$urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255)};
    begin_txn("t5");
    feed("t5", 0, 1'b1);
    finish_txn("t5", 1, 1'b0);

    // randomized transactions with random gaps, hold time and chaining
    in_accum = 1'b0;
    for (int n = 0; n < 12; n++) begin
      bit b2b = 1'(($urandom_range(0, 2) == 0) && n != 11);
      q_terms = '{$urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255)};
      if (!in_accum) begin_txn("rnd");
      feed("rnd", 2, 1'($urandom_range(0, 1)));
      finish_txn("rnd", $urandom_range(0, 3), b2b);
      in_accum = b2b;
    end

    // asynchronous reset mid-accumulation
    q_terms = '{7, 9};
    begin_txn("t6");
    feed("t6", 0, 1'b0);
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    check_ctrl("t6_async_rst", 1'b0, 1'b0, 1'b0);
    check_acc("t6_async_rst", 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    q_terms = '{1, 1, 1, 1};
    begin_txn("t6b");
    feed("t6b", 0, 1'b0);
    finish_txn("t6b", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Multiply-accumulate back end that sits directly downstream of the datapath multiplier.
- Consumes a stream of unsigned products under a valid/ready handshake and sums exactly NTERMS of them into a wider accumulator.
- Presents the completed sum on a held valid/ready output.
- Used to build dot-product and FIR-style datapaths from the existing combinational component library.

Parameters:
- DATAWIDTH, 8, width of each incoming product (matches multiplier DATAWIDTH).
- ACCWIDTH, 16, accumulator/result width; must be >= DATAWIDTH.
- NTERMS, 4, number of products summed per result; must be >= 1.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low.
- start  input  1  begin a new accumulation; honoured only in IDLE, or in HOLD while acc_ready=1.
- prod  input  DATAWIDTH  unsigned product from upstream multiplier.
- prod_valid  input  1  prod holds a valid term.
- prod_ready  output  1  block accepts a term this cycle.
- acc  output  ACCWIDTH  accumulated result / running sum.
- acc_valid  output  1  acc holds a completed result.
- acc_ready  input  1  downstream consumes result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock domain (Clk). Reset is asynchronous and active-low on Rst. While Rst=0, all of the following hold immediately (no clock needed):
  - state=IDLE, acc=0, acc_valid=0, internal term counter=0.
  - prod_ready=0 and busy=0, since both are derived from state.
- FSM states: IDLE, ACCUM, HOLD.
- Output decoding: prod_ready = (state==ACCUM); busy = (state!=IDLE). Both are combinational from registered state, with no dependence on prod_valid.
- IDLE:
  - start=1 -> next edge: acc<=0, count<=0, state<=ACCUM.
  - prod_valid is ignored.
- ACCUM:
  - Transfer occurs on an edge where prod_valid=1 and prod_ready=1: acc <= acc + zero-extended prod, and count increments.
  - No transfer -> acc and count hold.
  - Transfer with count==NTERMS-1 -> state<=HOLD, acc_valid<=1, count<=0.
  - start is ignored in this state.
- HOLD:
  - acc and acc_valid are stable until acc_ready=1.
  - acc_ready=1 and start=0 -> acc_valid<=0, state<=IDLE; acc keeps its last value.
  - acc_ready=1 and start=1 -> acc_valid<=0, acc<=0, count<=0, state<=ACCUM. This is back-to-back operation with no IDLE bubble.
- Arithmetic: unsigned, modulo 2^ACCWIDTH (wrap-around) unless SATURATE_EN is defined. If ACCWIDTH==DATAWIDTH, prod is added unextended.
- Latency:
  - acc_valid rises on the edge of the NTERMS-th transfer and is visible the following cycle.
  - Minimum start-to-acc_valid is NTERMS+1 cycles with prod_valid held high.
- Throughput: one term per cycle in ACCUM.
- acc during ACCUM shows the running partial sum; it is meaningful only while acc_valid=1.
- Reset mid-operation discards the partial sum and count, with no result emitted.

Optional Feature:
- Macro: MAC_ACCUM_SATURATE_EN.
- Defined: if acc + prod exceeds 2^ACCWIDTH-1, acc clamps to all-ones and stays there for the remaining terms of that accumulation. The counter and handshake are unaffected.
- Undefined: plain modulo-2^ACCWIDTH wrap. No interface difference either way.

Test Plan:
1. Config DATAWIDTH=8, ACCWIDTH=16, NTERMS=4. Pulse start, then feed 10,20,30,40 with prod_valid held high -> acc_valid=1 one cycle after the 4th transfer with acc=100. acc_valid and acc stay 1/100 while acc_ready is held low for 5 cycles. acc_ready=1 -> acc_valid=0 and busy=0 the next cycle.
2. Same config. Feed 1,2,3,4 with prod_valid low on alternate cycles -> acc=10, count advances only on valid cycles. Additionally assert prod_valid=1 in IDLE -> prod_ready=0 and acc unchanged.
3. Config ACCWIDTH=9, NTERMS=4. Feed 255 x4 -> acc=508 without the macro, and acc=511 with MAC_ACCUM_SATURATE_EN defined.
4. Back-to-back: in HOLD (acc=100), assert acc_ready=1 and start=1 together -> next cycle state=ACCUM, acc=0, acc_valid=0, busy stays 1. Then feed 5 x4 -> acc=20.
5. Assert start again while in ACCUM after 2 terms -> ignored; the final result still sums exactly 4 terms.
6. Drive Rst=0 asynchronously mid-ACCUM after 2 terms (between clock edges) -> acc=0, acc_valid=0, prod_ready=0, busy=0 immediately. After release, a fresh start with 1,1,1,1 gives acc=4.
